// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel mechanical key debouncer. Raw key pins are synchronised
//   internally, then each channel runs its own debounce state machine on a
//   shared 1 ms timebase. Each channel provides a debounced level, one-cycle
//   press/release pulses and a one-shot long-press pulse.
//
// Ports
//   CLK           system clock
//   RST           synchronous, active-high reset
//   Key_In        raw asynchronous key pins (IDLE_LEVEL when released)
//   Key_Level     debounced pin level, IDLE_LEVEL while released
//   Press_Pulse   1-cycle pulse when a press is accepted
//   Release_Pulse 1-cycle pulse when a release is accepted
//   Long_Pulse    1-cycle pulse after LONG_MS of hold, at most once per press
//   Tick_1ms      shared 1 ms timebase pulse
module key_debounce_multi #(
    parameter int   NUM_KEYS    = 4,
    parameter int   CLK_PER_MS  = 20000,
    parameter int   DEBOUNCE_MS = 10,
    parameter int   LONG_MS     = 1000,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] Key_In,
    output logic [NUM_KEYS-1:0] Key_Level,
    output logic [NUM_KEYS-1:0] Press_Pulse,
    output logic [NUM_KEYS-1:0] Release_Pulse,
    output logic [NUM_KEYS-1:0] Long_Pulse,
    output logic                Tick_1ms
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = (LONG_MS > 0) ? $clog2(LONG_MS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] LONG_LAST  = HW'((LONG_MS > 0) ? LONG_MS - 1 : 0);
    localparam logic [HW-1:0] LONG_MAX   = HW'(LONG_MS);
    localparam logic [NUM_KEYS-1:0] IDLE_VEC = {NUM_KEYS{IDLE_LEVEL}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DEB,
        S_PRESSED,
        S_RELEASE_DEB
    } state_t;

    // Shared prescaler and input synchroniser
    logic [PW-1:0]       presc_q, presc_d;
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic                tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        sync1_d = Key_In;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            sync1_q <= IDLE_VEC;
            sync2_q <= IDLE_VEC;
        end else begin
            presc_q <= presc_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign Tick_1ms = tick;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        state_t          state_q, state_d;
        logic [DW-1:0]   deb_q, deb_d;
        logic [HW-1:0]   hold_q, hold_d;
        logic            done_q, done_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            rel_q, rel_d;
        logic            long_q, long_d;
        logic            pressed;

        assign pressed = (sync2_q[g] != IDLE_LEVEL);

        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            hold_d  = hold_q;
            done_d  = done_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (pressed) begin
                        state_d = S_PRESS_DEB;
                        deb_d   = '0;
                    end
                end
                S_PRESS_DEB: begin
                    if (!pressed) begin
                        state_d = S_IDLE;
                    end else if (tick) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = S_PRESSED;
                            level_d = ~IDLE_LEVEL;
                            press_d = 1'b1;
                            hold_d  = '0;
                            done_d  = 1'b0;
                        end else begin
                            deb_d = deb_q + DW'(1);
                        end
                    end
                end
                S_PRESSED: begin
                    if (!pressed) begin
                        state_d = S_RELEASE_DEB;
                        deb_d   = '0;
                    end
                end
                S_RELEASE_DEB: begin
                    // hold_q is left alone so a release glitch does not
                    // restart the long-press timer.
                    if (pressed) begin
                        state_d = S_PRESSED;
                        deb_d   = '0;
                    end else if (tick) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = S_IDLE;
                            level_d = IDLE_LEVEL;
                            rel_d   = 1'b1;
                        end else begin
                            deb_d = deb_q + DW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Long-press timer runs while the key is held or its release is
            // still being debounced; it saturates and fires only once.
            if ((LONG_MS != 0) && tick &&
                ((state_q == S_PRESSED) || (state_q == S_RELEASE_DEB))) begin
                if ((hold_q == LONG_LAST) && !done_q) begin
                    long_d = 1'b1;
                    done_d = 1'b1;
                end
                if (hold_q != LONG_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= S_IDLE;
                deb_q   <= '0;
                hold_q  <= '0;
                done_q  <= 1'b0;
                level_q <= IDLE_LEVEL;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                done_q  <= done_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        assign Key_Level[g]     = level_q;
        assign Press_Pulse[g]   = press_q;
        assign Release_Pulse[g] = rel_q;
        assign Long_Pulse[g]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] key_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic       tick_1ms;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .NUM_KEYS   (2),
        .CLK_PER_MS (4),
        .DEBOUNCE_MS(3),
        .LONG_MS    (10),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .Key_In       (key_in),
        .Key_Level    (key_level),
        .Press_Pulse  (press_pulse),
        .Release_Pulse(release_pulse),
        .Long_Pulse   (long_pulse),
        .Tick_1ms     (tick_1ms)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int ch;
        int kind;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];

    task automatic expect_evt(input int ch, input int kind, input int lo, input int hi);
        exp_t e;
        e.ch = ch; e.kind = kind; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    function automatic string kname(input int k);
        return (k == K_PRESS) ? "press" : (k == K_RELEASE) ? "release" : "long";
    endfunction

    // Every pulse must match an outstanding expectation and land in its window.
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < 3; k++) begin : per_kind
                    logic [1:0] vec;
                    int idx;
                    vec = (k == K_PRESS) ? press_pulse :
                          (k == K_RELEASE) ? release_pulse : long_pulse;
                    if (vec[ch]) begin
                        idx = -1;
                        foreach (sb[j])
                            if (idx < 0 && sb[j].ch == ch && sb[j].kind == k) idx = j;
                        if (idx < 0) begin
                            check($sformatf("unexpected %s ch%0d at cyc %0d", kname(k), ch, cyc), 1, 0);
                        end else begin
                            check($sformatf("%s ch%0d window [%0d,%0d] at cyc %0d",
                                            kname(k), ch, sb[idx].lo, sb[idx].hi, cyc),
                                  32'((cyc >= sb[idx].lo) && (cyc <= sb[idx].hi)), 1);
                            if (k != K_LONG)
                                check($sformatf("level with %s ch%0d", kname(k), ch),
                                      32'(key_level >> ch) & 32'd1, (k == K_PRESS) ? 0 : 1);
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_key(input int ch);
        int n;
        n = cyc;
        key_in[ch] = 1'b1;
        expect_evt(ch, K_RELEASE, n + 12, n + 15);
        wait_cyc(20);
    endtask

    int n;
    int r;

    initial begin
        rst    = 1'b1;
        key_in = 2'b00;

        // 1: reset state and timebase
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst level", key_level, 2'b11);
            check("rst pulses", {press_pulse, release_pulse, long_pulse}, 0);
            check("rst tick", tick_1ms, 0);
        end
        rst    = 1'b0;
        key_in = 2'b11;
        r      = cyc;
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("tick at cyc %0d", cyc), tick_1ms, ((cyc - r) % 4) == 3);
        end

        // 2: clean press on channel 0
        n = cyc;
        key_in[0] = 1'b0;
        expect_evt(0, K_PRESS, n + 12, n + 15);
        wait_cyc(20);
        check("level after clean press", key_level, 2'b10);
        release_key(0);
        check("level after clean release", key_level, 2'b11);

        // 3: bounce then settle
        key_in[0] = 1'b0; wait_cyc(5);
        key_in[0] = 1'b1; wait_cyc(5);
        key_in[0] = 1'b0; wait_cyc(5);
        key_in[0] = 1'b1; wait_cyc(5);
        check("level during bounce", key_level, 2'b11);
        n = cyc;
        key_in[0] = 1'b0;
        expect_evt(0, K_PRESS, n + 12, n + 15);
        wait_cyc(20);
        release_key(0);

        // 4: long press on channel 1
        n = cyc;
        key_in[1] = 1'b0;
        expect_evt(1, K_PRESS, n + 12, n + 15);
        expect_evt(1, K_LONG,  n + 52, n + 55);
        wait_cyc(60);
        check("level during long hold", key_level, 2'b01);
        release_key(1);
        check("level after long release", key_level, 2'b11);

        // 5: release glitch during hold keeps the long timer
        n = cyc;
        key_in[1] = 1'b0;
        expect_evt(1, K_PRESS, n + 12, n + 15);
        expect_evt(1, K_LONG,  n + 52, n + 55);
        wait_cyc(25);
        key_in[1] = 1'b1;
        wait_cyc(5);
        key_in[1] = 1'b0;
        wait_cyc(35);
        check("level after glitch", key_level, 2'b01);
        release_key(1);

        // 6: reset mid-hold, key still held
        n = cyc;
        key_in[1] = 1'b0;
        expect_evt(1, K_PRESS, n + 12, n + 15);
        wait_cyc(25);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        check("level after mid-hold reset", key_level, 2'b11);
        check("pulses after mid-hold reset", {press_pulse, release_pulse, long_pulse}, 0);
        expect_evt(1, K_PRESS, r + 12, r + 15);
        expect_evt(1, K_LONG,  r + 52, r + 55);
        wait_cyc(60);
        check("level after re-press", key_level, 2'b01);
        release_key(1);

        // 7: simultaneous press on both channels
        n = cyc;
        key_in = 2'b00;
        expect_evt(0, K_PRESS, n + 12, n + 15);
        expect_evt(1, K_PRESS, n + 12, n + 15);
        wait_cyc(18);
        check("level both pressed", key_level, 2'b00);
        n = cyc;
        key_in = 2'b11;
        expect_evt(0, K_RELEASE, n + 12, n + 15);
        expect_evt(1, K_RELEASE, n + 12, n + 15);
        wait_cyc(30);

        check("outstanding expectations", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
